// File: rtl/text_pkg.sv
// Character codes and controller state encoding shared by the text write path.
package text_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/text_write_ctrl_if.sv
// Character strobe in, text-buffer write port and cursor out.
// master = character source, slave = the write controller.
interface text_write_ctrl_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  ready;
    logic                  we;
    logic [DATA_WIDTH-1:0] din;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] cursor_addr;

    modport master (
        output rx_data, rx_valid,
        input  ready, we, din, addr_a, cursor_addr
    );

    modport slave (
        input  rx_data, rx_valid,
        output ready, we, din, addr_a, cursor_addr
    );
endinterface

// File: rtl/text_write_ctrl.sv
// Text buffer write controller: clears the screen, then turns character strobes into cell writes.
// Latency: write and cursor update appear one cycle after the accepted strobe.
// Backpressure: ready is low during a clear; strobes seen while not ready are dropped.
module text_write_ctrl
    import text_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int COL_BITS   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    text_write_ctrl_if.slave   bus
);

    localparam int ROW_BITS = ADDR_WIDTH - COL_BITS;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ROW_BITS-1:0]   ROW_ONE   = ROW_BITS'(1);
    localparam logic [DATA_WIDTH-1:0] SPACE     = DATA_WIDTH'(CH_SPACE);
    localparam logic [DATA_WIDTH-1:0] TILDE     = DATA_WIDTH'(CH_TILDE);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  we_q, we_d;

    logic [ROW_BITS-1:0]   row;
    logic [COL_BITS-1:0]   col;
    logic                  printable;

    assign row       = cursor_q[ADDR_WIDTH-1:COL_BITS];
    assign col       = cursor_q[COL_BITS-1:0];
    assign printable = (bus.rx_data >= SPACE) && (bus.rx_data <= TILDE);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cursor_d  = cursor_q;
        we_d      = 1'b0;
        din_d     = din_q;
        addr_d    = addr_q;

        if (state_q == ST_CLEAR) begin
            we_d      = 1'b1;
            din_d     = SPACE;
            addr_d    = clr_cnt_q;
            clr_cnt_d = clr_cnt_q + ADDR_ONE;
            cursor_d  = '0;
            if (clr_cnt_q == ADDR_LAST) begin
                state_d = ST_IDLE;
            end
        end else if (bus.rx_valid) begin
            if (printable) begin
                we_d     = 1'b1;
                din_d    = bus.rx_data;
                addr_d   = cursor_q;
                cursor_d = cursor_q + ADDR_ONE;
            end else if (bus.rx_data == DATA_WIDTH'(CH_CR)) begin
                cursor_d = {row, {COL_BITS{1'b0}}};
            end else if (bus.rx_data == DATA_WIDTH'(CH_LF)) begin
                cursor_d = {row + ROW_ONE, col};
            end else if (bus.rx_data == DATA_WIDTH'(CH_BS)) begin
                // Backspace at the home cell blanks it in place rather than wrapping.
                we_d  = 1'b1;
                din_d = SPACE;
                if (cursor_q != '0) begin
                    cursor_d = cursor_q - ADDR_ONE;
                    addr_d   = cursor_q - ADDR_ONE;
                end else begin
                    addr_d   = '0;
                end
            end else if (bus.rx_data == DATA_WIDTH'(CH_FF)) begin
                cursor_d  = '0;
                clr_cnt_d = '0;
                state_d   = ST_CLEAR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            cursor_q  <= '0;
            we_q      <= 1'b0;
            din_q     <= SPACE;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            cursor_q  <= cursor_d;
            we_q      <= we_d;
            din_q     <= din_d;
            addr_q    <= addr_d;
        end
    end

    assign bus.ready       = (state_q == ST_IDLE);
    assign bus.we          = we_q;
    assign bus.din         = din_q;
    assign bus.addr_a      = addr_q;
    assign bus.cursor_addr = cursor_q;

endmodule
